vend_change_payout: RTL and testbench

Coin-return controller on the receiving end of the vending FSM's dispense/change outputs. It converts a 2-bit change code (0/25/50/75 cents) into N quarter ejections (N = 0..3), driving the hopper solenoid and confirming each coin on the hopper exit sensor. It tracks quarter inventory and flags jams and empty-hopper faults. It resumes the owed payout after a service refill.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/vend_cycle_timer.sv | 28 ++
 rtl/vend_change_payout.sv | 178 +++++++++++++++++
 tb/tb_vend_change_payout.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// Shared constants and state encoding for the coin-return payout block.
package vend_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_25   = 2'b01;
  localparam logic [1:0] CHG_50   = 2'b10;
  localparam logic [1:0] CHG_75   = 2'b11;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PULSE      = 3'd1,
    WAIT_SENSE = 3'd2,
    GAP        = 3'd3,
    FAULT      = 3'd4
  } state_e;

  localparam int DEF_PULSE_CYCLES   = 8;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_INV_W          = 8;
  localparam int DEF_INV_INIT       = 20;

endpackage
`default_nettype wire

// File: rtl/vend_cycle_timer.sv
`default_nettype none
// Loadable down-counter; expired_o is high while the count sits at zero.
module vend_cycle_timer #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/vend_change_payout.sv
`default_nettype none
// Quarter payout controller: ejects owed change coin by coin, confirms each
// on the exit sensor, tracks inventory and parks in FAULT on jam or empty hopper.
module vend_change_payout
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int INV_W          = DEF_INV_W,
  parameter int INV_INIT       = DEF_INV_INIT
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             dispense,
  input  logic [1:0]       change,
  input  logic             coin_sensed,
  input  logic             refill,
  input  logic [INV_W-1:0] refill_qty,
  output logic             eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic             empty,
  output logic [INV_W-1:0] quarters_left,
  output logic [1:0]       owed
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  // Whatever is left of the jam window once the pulse has finished.
  localparam logic [TW-1:0] WAIT_LOAD  = TW'(TIMEOUT_CYCLES - PULSE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [1:0]       owed_q, owed_d;
  logic             sensed_q, sensed_d;
  logic             done_q, done_d;
  logic [INV_W-1:0] inv_q, inv_d;

  logic             t_load;
  logic [TW-1:0]    t_val;
  logic             t_expired;
  logic             accept;

  logic [INV_W:0]   refill_add;
  logic [INV_W:0]   sum_refill;
  logic [INV_W:0]   sum_net;
  logic [INV_W-1:0] inv_after_refill;

  vend_cycle_timer #(.W(TW)) u_timer (
    .clock     (clock),
    .rst       (rst),
    .load_i    (t_load),
    .value_i   (t_val),
    .expired_o (t_expired)
  );

  // A coin counts once the pulse has run its full length, or on any sense while waiting.
  assign accept = ((state_q == PULSE) && t_expired && (sensed_q || coin_sensed)) ||
                  ((state_q == WAIT_SENSE) && coin_sensed);

  assign refill_add       = refill ? {1'b0, refill_qty} : '0;
  assign sum_refill       = {1'b0, inv_q} + refill_add;
  assign inv_after_refill = sum_refill[INV_W] ? '1 : sum_refill[INV_W-1:0];
  assign sum_net          = sum_refill - {{INV_W{1'b0}}, accept};
  assign inv_d            = sum_net[INV_W] ? '1 : sum_net[INV_W-1:0];

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    owed_d   = owed_q;
    sensed_d = sensed_q;
    done_d   = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;

    unique case (state_q)
      IDLE: begin
        if (dispense) begin
          if (change == CHG_NONE) begin
            done_d = 1'b1;
          end else begin
            rem_d    = change;
            sensed_d = 1'b0;
            if (inv_after_refill != '0) begin
              state_d = PULSE;
              t_load  = 1'b1;
              t_val   = PULSE_LOAD;
            end else begin
              state_d = FAULT;
              owed_d  = change;
            end
          end
        end
      end
      PULSE: begin
        if (coin_sensed) sensed_d = 1'b1;
        if (t_expired && !accept) begin
          state_d = WAIT_SENSE;
          t_load  = 1'b1;
          t_val   = WAIT_LOAD;
        end
      end
      WAIT_SENSE: begin
        if (!accept && t_expired) begin
          state_d = FAULT;
          owed_d  = rem_q;
        end
      end
      GAP: begin
        if (t_expired) begin
          if (inv_after_refill != '0) begin
            state_d = PULSE;
            t_load  = 1'b1;
            t_val   = PULSE_LOAD;
          end else begin
            state_d = FAULT;
            owed_d  = rem_q;
          end
        end
      end
      FAULT: begin
        if (refill && (inv_after_refill != '0)) begin
          state_d  = PULSE;
          rem_d    = owed_q;
          owed_d   = 2'd0;
          sensed_d = 1'b0;
          t_load   = 1'b1;
          t_val    = PULSE_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sensed_d = 1'b0;
      rem_d    = rem_q - 2'd1;
      if (rem_q == 2'd1) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = GAP;
        t_load  = 1'b1;
        t_val   = GAP_LOAD;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rem_q    <= 2'd0;
      owed_q   <= 2'd0;
      sensed_q <= 1'b0;
      done_q   <= 1'b0;
      inv_q    <= INV_W'(INV_INIT);
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      owed_q   <= owed_d;
      sensed_q <= sensed_d;
      done_q   <= done_d;
      inv_q    <= inv_d;
    end
  end

  assign eject         = (state_q == PULSE);
  assign busy          = (state_q != IDLE);
  assign fault         = (state_q == FAULT);
  assign done          = done_q;
  assign empty         = (inv_q == '0);
  assign quarters_left = inv_q;
  assign owed          = (state_q == FAULT) ? owed_q : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_vend_change_payout.sv
`default_nettype none
// Randomized scoreboard bench: a payout-level model predicts each done/fault
// event; a negedge monitor checks those events and the eject waveform.
module tb_vend_change_payout;

  localparam int PULSE   = 8;
  localparam int GAPC    = 4;
  localparam int TIMEOUT = 64;
  localparam int INIT    = 20;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       dispense = 1'b0;
  logic [1:0] change = 2'd0;
  logic       coin_sensed = 1'b0;
  logic       refill = 1'b0;
  logic [7:0] refill_qty = 8'd0;
  logic       eject, busy, done, fault, empty;
  logic [7:0] quarters_left;
  logic [1:0] owed;

  vend_change_payout #(
    .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TIMEOUT),
    .INV_W(8), .INV_INIT(INIT)
  ) dut (
    .clock(clock), .rst(rst), .dispense(dispense), .change(change),
    .coin_sensed(coin_sensed), .refill(refill), .refill_qty(refill_qty),
    .eject(eject), .busy(busy), .done(done), .fault(fault), .empty(empty),
    .quarters_left(quarters_left), .owed(owed)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_fault;
    int qleft;
    int owed;
    int ejects;
    bit jam;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Payout-level reference state
  int m_inv = INIT;
  bit m_fault = 0;
  int m_owed = 0;

  // Hopper behaviour driven by the bench
  int jam_at = 0, hop_cnt = 0, hop_age = 0, hop_delay = 0, hop_fixed = -1, arm_qty = -1;
  bit hop_pending = 0, hop_prev = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic exp_t mk(bit f, int q, int o, int e, bit j);
    exp_t x;
    x.is_fault = f; x.qleft = q; x.owed = o; x.ejects = e; x.jam = j;
    return x;
  endfunction

  // Pay 'rem' quarters one by one; coin jam_at (1-based) never arrives.
  task automatic model_payout(int rem, int coinc_qty);
    int k = 0;
    bit first = 1;
    while (rem > 0) begin
      if (m_inv == 0) begin
        sbq.push_back(mk(1, m_inv, rem, k, 0));
        m_fault = 1; m_owed = rem;
        return;
      end
      k++;
      if (k == jam_at) begin
        sbq.push_back(mk(1, m_inv, rem, k, 1));
        m_fault = 1; m_owed = rem;
        return;
      end
      if (first && coinc_qty >= 0) m_inv = sat(m_inv + coinc_qty - 1);
      else m_inv = m_inv - 1;
      first = 0;
      rem--;
    end
    m_fault = 0;
    sbq.push_back(mk(0, m_inv, 0, k, 0));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    dispense = 1'b0;
    refill = 1'b0;
    coin_sensed = 1'b0;
    if (eject && !hop_prev) begin
      hop_cnt++;
      hop_age = 0;
      hop_pending = (hop_cnt != jam_at);
      hop_delay = (hop_fixed >= 0) ? hop_fixed : int'($urandom_range(0, 30));
    end else begin
      hop_age++;
    end
    if (hop_pending && hop_age == hop_delay) begin
      coin_sensed = 1'b1;
      hop_pending = 0;
      if (arm_qty >= 0) begin
        refill = 1'b1;
        refill_qty = 8'(arm_qty);
        arm_qty = -1;
      end
    end
    hop_prev = eject;
  endtask

  task automatic do_dispense(int c, int jam, int coinc);
    jam_at = jam; hop_cnt = 0; arm_qty = coinc;
    dispense = 1'b1; change = 2'(c);
    if (c == 0) sbq.push_back(mk(0, m_inv, 0, 0, 0));
    else model_payout(c, coinc);
    tick();
  endtask

  task automatic do_refill(int q);
    jam_at = 0; hop_cnt = 0;
    refill = 1'b1; refill_qty = 8'(q);
    m_inv = sat(m_inv + q);
    if (m_fault && m_inv > 0) begin
      m_fault = 0;
      model_payout(m_owed, -1);
    end
    tick();
  endtask

  task automatic wait_settle();
    int n = 0;
    while (!(sbq.size() == 0 && (fault || !busy)) && n < 800) begin
      tick();
      n++;
    end
    if (n >= 800) begin
      checks++; errors++;
      $display("FAIL settle_timeout: got %0d pending events, required 0 within 800 cycles", sbq.size());
      sbq.delete();
    end
    check("fault_state", fault, m_fault);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    rst = 1'b0;
    #1;
    check("eject_async_reset", eject, 0);
    check("busy_async_reset", busy, 0);
    sbq.delete();
    m_inv = INIT; m_fault = 0; m_owed = 0;
    hop_pending = 0; hop_prev = 0; arm_qty = -1; jam_at = 0; hop_fixed = -1;
    dispense = 1'b0; refill = 1'b0; coin_sensed = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #3;
    rst = 1'b1;
    tick();
    check("rst_qleft", quarters_left, INIT);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_owed", owed, 0);
  endtask

  // Monitor
  int cyc = 0, rises = 0, rise_cyc = 0, ej_high = 0, ej_low = 0, sense_low = 0;
  bit prev_e = 0, prev_f = 0, gap_valid = 0;
  exp_t mon_e;

  always @(negedge clock) begin
    if (!rst) begin
      rises = 0; ej_high = 0; ej_low = 0; sense_low = 0;
      prev_e = 0; prev_f = 0; gap_valid = 0;
    end else begin
      cyc++;
      if (eject && !prev_e) begin
        if (gap_valid) check("eject_gap", ej_low, sense_low + GAPC);
        rises++; rise_cyc = cyc; ej_high = 1;
      end else if (eject) begin
        ej_high++;
      end else if (prev_e) begin
        check("eject_width", ej_high, PULSE);
        gap_valid = 1; ej_low = 1; sense_low = 0;
      end else begin
        ej_low++;
      end
      if (coin_sensed && !eject && gap_valid && sense_low == 0) sense_low = ej_low;
      if (done || (fault && !prev_f)) begin
        gap_valid = 0;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got done=%0d fault=%0d, required no event", done, fault);
        end else begin
          mon_e = sbq.pop_front();
          check("event_is_fault", fault, mon_e.is_fault);
          check("event_qleft", quarters_left, mon_e.qleft);
          check("event_owed", owed, mon_e.owed);
          check("event_ejects", rises, mon_e.ejects);
          if (mon_e.is_fault) begin
            check("fault_eject", eject, 0);
            check("fault_done", done, 0);
            check("fault_empty", empty, (mon_e.qleft == 0) ? 1 : 0);
            if (mon_e.jam) check("jam_latency", cyc - rise_cyc, TIMEOUT);
          end else begin
            check("done_busy", busy, 0);
          end
        end
        rises = 0;
      end
      prev_e = eject;
      prev_f = fault;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, j;
    do_reset();

    // Zero change: done next cycle, no eject
    do_dispense(0, 0, -1);
    check("zero_done_n1", done, 1);
    check("zero_no_eject", eject, 0);
    wait_settle();
    check("zero_qleft", quarters_left, 20);

    // Three quarters, sensed early in each pulse
    hop_fixed = 3;
    do_dispense(3, 0, -1);
    check("eject_n1", eject, 1);
    wait_settle();
    check("three_qleft", quarters_left, 17);
    check("three_busy", busy, 0);

    // Jam on first coin, then refill resumes
    do_reset();
    do_dispense(2, 1, -1);
    wait_settle();
    check("jam_owed", owed, 2);
    do_refill(5);
    wait_settle();
    check("resume_qleft", quarters_left, 23);

    // Randomized payouts with jams, refills and empty-hopper faults
    for (int it = 0; it < 25; it++) begin
      c = int'($urandom_range(0, 3));
      j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (m_inv < 4 && $urandom_range(0, 1) == 1) begin
        do_refill(int'($urandom_range(0, 6)));
        wait_settle();
      end
      do_dispense(c, j, -1);
      wait_settle();
      for (int g = 0; g < 5 && m_fault; g++) begin
        do_refill((g == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(1, 5)));
        wait_settle();
      end
    end

    // Drain to one quarter, then owe three
    do_reset();
    for (int k = 0; k < 6; k++) begin
      do_dispense(3, 0, -1);
      wait_settle();
    end
    do_dispense(1, 0, -1);
    wait_settle();
    check("drain_qleft", quarters_left, 1);
    do_dispense(3, 0, -1);
    wait_settle();
    check("empty_fault_owed", owed, 2);
    check("empty_flag", empty, 1);
    do_refill(0);
    repeat (3) tick();
    check("refill0_fault", fault, 1);
    check("refill0_owed", owed, 2);
    do_refill(3);
    wait_settle();
    check("refill3_qleft", quarters_left, 1);

    // Refill coincident with an accepted coin, then saturation
    do_reset();
    hop_fixed = 10;
    do_dispense(1, 0, 10);
    wait_settle();
    check("coinc_qleft", quarters_left, 29);
    do_refill(221);
    check("refill_250", quarters_left, 250);
    do_refill(10);
    check("refill_sat", quarters_left, 255);

    // Asynchronous reset in the middle of a pulse, then a spurious sense
    do_reset();
    hop_fixed = 3;
    do_dispense(3, 0, -1);
    tick();
    tick();
    check("eject_pre_reset", eject, 1);
    do_reset();
    coin_sensed = 1'b1;
    tick();
    tick();
    check("spurious_qleft", quarters_left, 20);
    check("spurious_busy", busy, 0);
    check("spurious_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
